regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and an out-of-band long-latency unit (multiply/divide). It keeps a scoreboard of registers with long-latency writes in flight, raises a decode stall on RAW/WAW hazards against them, and buffers long-latency results in a small FIFO while writeback owns the port. It sits between the writeback stage, the long-latency unit and the register file's WriteEnable/RegisterDestination/WriteData inputs.

---
 rtl/regfile_write_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between the in-order writeback
// stage and an out-of-band long-latency unit (multiply/divide).
//   - Scoreboard (pending_q) of registers with long-latency writes in flight,
//     used to stall decode on RAW/WAW hazards.
//   - DEPTH-entry FIFO that buffers long-latency results while writeback
//     owns the write port.
//   - Sticky ErrorWaw flag when writeback targets a register that still has a
//     long-latency write in flight.
//
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   WbWriteEnable/WbRegister/WbData           writeback request
//   LuIssue/LuIssueRegister -> LuIssueReady   long-latency issue handshake
//   LuResultValid/Register/Data -> LuResultReady  long-latency result handshake
//   DecodeRs1/Rs2/Rd/RegWrite -> StallD       decode hazard check
//   WriteEnable/RegisterDestination/WriteData register-file write port
//   ErrorWaw                                  sticky protocol-error flag
module regfile_write_arbiter #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WbWriteEnable,
  input  logic [4:0]  WbRegister,
  input  logic [31:0] WbData,
  input  logic        LuIssue,
  input  logic [4:0]  LuIssueRegister,
  output logic        LuIssueReady,
  input  logic        LuResultValid,
  input  logic [4:0]  LuResultRegister,
  input  logic [31:0] LuResultData,
  output logic        LuResultReady,
  input  logic [4:0]  DecodeRs1,
  input  logic [4:0]  DecodeRs2,
  input  logic [4:0]  DecodeRd,
  input  logic        DecodeRegWrite,
  output logic        StallD,
  output logic        WriteEnable,
  output logic [4:0]  RegisterDestination,
  output logic [31:0] WriteData,
  output logic        ErrorWaw
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

  // State
  logic [31:0]   pending_q, pending_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [4:0]    fifo_reg_q  [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          error_waw_q, error_waw_d;

  // Combinational control
  logic          wb_active_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          res_hs_s;
  logic          res_nz_s;
  logic          issue_hs_s;
  logic          pop_s;
  logic          bypass_s;
  logic          push_s;
  logic          clr_en_s;
  logic [4:0]    clr_reg_s;
  logic          we_s;
  logic [4:0]    dest_s;
  logic [31:0]   data_s;

  assign wb_active_s  = WbWriteEnable && (WbRegister != 5'd0);
  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == FULL_CNT);

  // Space is judged on the registered count only, so a same-cycle pop never
  // creates room for a new result.
  assign LuResultReady = !rst && !fifo_full_s;
  assign res_hs_s      = LuResultValid && LuResultReady;
  assign res_nz_s      = res_hs_s && (LuResultRegister != 5'd0);

  // A register already pending may not be re-issued: a second in-flight write
  // to it would make the single scoreboard bit ambiguous.
  assign LuIssueReady = !rst && (outstanding_q < MAX_OUT) &&
                        !((LuIssueRegister != 5'd0) && pending_q[LuIssueRegister]);
  assign issue_hs_s   = LuIssue && LuIssueReady;

  // Write-port grant: writeback first, then FIFO head, then direct bypass.
  always_comb begin
    we_s      = 1'b0;
    dest_s    = 5'd0;
    data_s    = 32'd0;
    pop_s     = 1'b0;
    bypass_s  = 1'b0;
    clr_en_s  = 1'b0;
    clr_reg_s = 5'd0;
    if (rst) begin
      we_s = 1'b0;
    end else if (wb_active_s) begin
      we_s   = 1'b1;
      dest_s = WbRegister;
      data_s = WbData;
    end else if (!fifo_empty_s) begin
      we_s      = 1'b1;
      dest_s    = fifo_reg_q[rd_ptr_q];
      data_s    = fifo_data_q[rd_ptr_q];
      pop_s     = 1'b1;
      clr_en_s  = 1'b1;
      clr_reg_s = fifo_reg_q[rd_ptr_q];
    end else if (res_nz_s) begin
      we_s      = 1'b1;
      dest_s    = LuResultRegister;
      data_s    = LuResultData;
      bypass_s  = 1'b1;
      clr_en_s  = 1'b1;
      clr_reg_s = LuResultRegister;
    end else begin
      we_s = 1'b0;
    end
  end

  // Only non-zero results that did not go straight to the port are queued.
  assign push_s = res_nz_s && !bypass_s;

  // Next-state for scoreboard, outstanding count, FIFO pointers and error flag.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    error_waw_d   = error_waw_q;

    // Clear before set; the same register cannot be both in one cycle.
    if (clr_en_s) begin
      pending_d[clr_reg_s] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (issue_hs_s && (LuIssueRegister != 5'd0)) begin
      pending_d[LuIssueRegister] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;

    case ({issue_hs_s, res_hs_s})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      // Saturate at zero so a stray result cannot wrap the counter.
      2'b01:   outstanding_d = (outstanding_q != 4'd0) ? (outstanding_q - 4'd1) : 4'd0;
      default: outstanding_d = outstanding_q;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Writeback still wins the port; the conflict is only flagged.
    if (wb_active_s && pending_q[WbRegister]) begin
      error_waw_d = 1'b1;
    end else begin
      error_waw_d = error_waw_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= 32'd0;
      outstanding_q <= 4'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      error_waw_q   <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      error_waw_q   <= error_waw_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_reg_q[wr_ptr_q]  <= LuResultRegister;
      fifo_data_q[wr_ptr_q] <= LuResultData;
    end
  end

  assign StallD = !rst && (
                  ((DecodeRs1 != 5'd0) && pending_q[DecodeRs1]) ||
                  ((DecodeRs2 != 5'd0) && pending_q[DecodeRs2]) ||
                  (DecodeRegWrite && (DecodeRd != 5'd0) && pending_q[DecodeRd]));

  assign WriteEnable         = we_s;
  assign RegisterDestination = dest_s;
  assign WriteData           = data_s;
  assign ErrorWaw            = !rst && error_waw_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (DEPTH=2, MAX_OUTSTANDING=4).
// Inputs change 1 time unit after each rising edge; outputs are checked one
// time unit later, well away from the next edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        WbWriteEnable;
  logic [4:0]  WbRegister;
  logic [31:0] WbData;
  logic        LuIssue;
  logic [4:0]  LuIssueRegister;
  logic        LuIssueReady;
  logic        LuResultValid;
  logic [4:0]  LuResultRegister;
  logic [31:0] LuResultData;
  logic        LuResultReady;
  logic [4:0]  DecodeRs1, DecodeRs2, DecodeRd;
  logic        DecodeRegWrite;
  logic        StallD;
  logic        WriteEnable;
  logic [4:0]  RegisterDestination;
  logic [31:0] WriteData;
  logic        ErrorWaw;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DEPTH(2), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .WbWriteEnable(WbWriteEnable), .WbRegister(WbRegister), .WbData(WbData),
    .LuIssue(LuIssue), .LuIssueRegister(LuIssueRegister), .LuIssueReady(LuIssueReady),
    .LuResultValid(LuResultValid), .LuResultRegister(LuResultRegister),
    .LuResultData(LuResultData), .LuResultReady(LuResultReady),
    .DecodeRs1(DecodeRs1), .DecodeRs2(DecodeRs2), .DecodeRd(DecodeRd),
    .DecodeRegWrite(DecodeRegWrite), .StallD(StallD),
    .WriteEnable(WriteEnable), .RegisterDestination(RegisterDestination),
    .WriteData(WriteData), .ErrorWaw(ErrorWaw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"},   {31'd0, WriteEnable}, {31'd0, we});
    chk({tag, ".dest"}, {27'd0, RegisterDestination}, {27'd0, rd});
    chk({tag, ".data"}, WriteData, d);
  endtask

  initial begin
    rst = 1'b1;
    WbWriteEnable = 1'b1; WbRegister = 5'd2; WbData = 32'h2222;
    LuIssue = 1'b0; LuIssueRegister = 5'd0;
    LuResultValid = 1'b1; LuResultRegister = 5'd3; LuResultData = 32'h3333;
    DecodeRs1 = 5'd0; DecodeRs2 = 5'd0; DecodeRd = 5'd0; DecodeRegWrite = 1'b0;

    // ---- reset: two cycles, requests present, nothing may come out
    #1;
    chk_port("rst0", 1'b0, 5'd0, 32'd0);
    chk("rst0.issue_rdy", {31'd0, LuIssueReady}, 32'd0);
    chk("rst0.res_rdy",   {31'd0, LuResultReady}, 32'd0);
    chk("rst0.stall",     {31'd0, StallD}, 32'd0);
    chk("rst0.err",       {31'd0, ErrorWaw}, 32'd0);
    step();
    chk_port("rst1", 1'b0, 5'd0, 32'd0);
    chk("rst1.res_rdy", {31'd0, LuResultReady}, 32'd0);
    step();
    rst = 1'b0; WbWriteEnable = 1'b0; LuResultValid = 1'b0;
    #1;
    chk("post_rst.issue_rdy", {31'd0, LuIssueReady}, 32'd1);
    chk("post_rst.res_rdy",   {31'd0, LuResultReady}, 32'd1);
    chk("post_rst.stall",     {31'd0, StallD}, 32'd0);
    chk_port("post_rst", 1'b0, 5'd0, 32'd0);
    step();

    // ---- bypass: issue x5, then result with writeback idle
    LuIssue = 1'b1; LuIssueRegister = 5'd5;
    #1; chk("byp.issue_rdy", {31'd0, LuIssueReady}, 32'd1);
    step();
    LuIssue = 1'b0; DecodeRs1 = 5'd5;
    #1; chk("byp.stall_set", {31'd0, StallD}, 32'd1);
    LuResultValid = 1'b1; LuResultRegister = 5'd5; LuResultData = 32'hDEAD;
    #1; chk_port("byp.write", 1'b1, 5'd5, 32'hDEAD);
    step();
    LuResultValid = 1'b0;
    #1;
    chk("byp.stall_clr", {31'd0, StallD}, 32'd0);
    chk_port("byp.idle", 1'b0, 5'd0, 32'd0);
    DecodeRs1 = 5'd0;
    step();

    // ---- contention: writeback x1..x4 while results for x6, x7 arrive
    LuIssue = 1'b1; LuIssueRegister = 5'd6; step();
    LuIssueRegister = 5'd7; step();
    LuIssue = 1'b0;
    WbWriteEnable = 1'b1; WbRegister = 5'd1; WbData = 32'h101;
    LuResultValid = 1'b1; LuResultRegister = 5'd6; LuResultData = 32'h11;
    #1; chk_port("cont.c1", 1'b1, 5'd1, 32'h101);
    chk("cont.c1.res_rdy", {31'd0, LuResultReady}, 32'd1);
    step();
    WbRegister = 5'd2; WbData = 32'h102;
    LuResultRegister = 5'd7; LuResultData = 32'h22;
    #1; chk_port("cont.c2", 1'b1, 5'd2, 32'h102);
    chk("cont.c2.res_rdy", {31'd0, LuResultReady}, 32'd1);
    step();
    WbRegister = 5'd3; WbData = 32'h103; LuResultValid = 1'b0;
    #1; chk_port("cont.c3", 1'b1, 5'd3, 32'h103);
    chk("cont.c3.full", {31'd0, LuResultReady}, 32'd0);
    step();
    WbRegister = 5'd4; WbData = 32'h104; DecodeRs1 = 5'd6;
    #1; chk_port("cont.c4", 1'b1, 5'd4, 32'h104);
    chk("cont.c4.full", {31'd0, LuResultReady}, 32'd0);
    chk("cont.c4.stall", {31'd0, StallD}, 32'd1);
    step();
    WbWriteEnable = 1'b0;
    #1; chk_port("cont.drain6", 1'b1, 5'd6, 32'h11);
    chk("cont.pop_no_space", {31'd0, LuResultReady}, 32'd0);
    step();
    #1; chk_port("cont.drain7", 1'b1, 5'd7, 32'h22);
    chk("cont.space", {31'd0, LuResultReady}, 32'd1);
    chk("cont.stall_clr", {31'd0, StallD}, 32'd0);
    step();
    #1; chk_port("cont.empty", 1'b0, 5'd0, 32'd0);
    DecodeRs1 = 5'd0;
    step();

    // ---- limits: duplicate destination, then MAX_OUTSTANDING
    LuIssue = 1'b1; LuIssueRegister = 5'd8;
    #1; chk("lim.x8_first", {31'd0, LuIssueReady}, 32'd1);
    step();
    #1; chk("lim.x8_dup", {31'd0, LuIssueReady}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      LuIssueRegister = 5'(10 + i);
      #1; chk("lim.fill", {31'd0, LuIssueReady}, 32'd1);
      step();
    end
    LuIssueRegister = 5'd13;
    #1; chk("lim.max", {31'd0, LuIssueReady}, 32'd0);
    step();
    LuResultValid = 1'b1; LuResultRegister = 5'd8; LuResultData = 32'h88;
    #1; chk("lim.still_max", {31'd0, LuIssueReady}, 32'd0);
    chk_port("lim.res8", 1'b1, 5'd8, 32'h88);
    step();
    LuResultValid = 1'b0;
    #1; chk("lim.reopen", {31'd0, LuIssueReady}, 32'd1);
    step();
    LuIssue = 1'b0;
    LuResultValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      LuResultRegister = 5'(10 + i); LuResultData = 32'(16'hA0 + i);
      #1; chk_port("lim.drain", 1'b1, 5'(10 + i), 32'(16'hA0 + i));
      step();
    end
    LuResultValid = 1'b0;

    // ---- rd=0 issues count toward the limit but never block or write
    LuIssue = 1'b1; LuIssueRegister = 5'd0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("rd0.issue", {31'd0, LuIssueReady}, 32'd1);
      step();
    end
    #1; chk("rd0.counted", {31'd0, LuIssueReady}, 32'd0);
    LuIssue = 1'b0;
    LuResultValid = 1'b1; LuResultRegister = 5'd0; LuResultData = 32'hBAD;
    for (int i = 0; i < 4; i++) begin
      #1; chk("rd0.res_rdy", {31'd0, LuResultReady}, 32'd1);
      chk_port("rd0.no_write", 1'b0, 5'd0, 32'd0);
      step();
    end
    LuResultValid = 1'b0;
    #1; chk_port("rd0.fifo_empty", 1'b0, 5'd0, 32'd0);
    chk("rd0.freed", {31'd0, LuIssueReady}, 32'd1);

    // ---- WAW: x9 pending, decode writes x9, then writeback hits x9
    LuIssue = 1'b1; LuIssueRegister = 5'd9;
    step();
    LuIssue = 1'b0; DecodeRd = 5'd9; DecodeRegWrite = 1'b0;
    #1; chk("waw.no_regwrite", {31'd0, StallD}, 32'd0);
    DecodeRegWrite = 1'b1;
    #1; chk("waw.stall", {31'd0, StallD}, 32'd1);
    WbWriteEnable = 1'b1; WbRegister = 5'd9; WbData = 32'h999;
    #1; chk_port("waw.wb_wins", 1'b1, 5'd9, 32'h999);
    chk("waw.err_pre", {31'd0, ErrorWaw}, 32'd0);
    step();
    WbWriteEnable = 1'b0;
    #1; chk("waw.err_set", {31'd0, ErrorWaw}, 32'd1);
    chk("waw.still_pending", {31'd0, StallD}, 32'd1);
    step();
    #1; chk("waw.err_sticky", {31'd0, ErrorWaw}, 32'd1);
    DecodeRegWrite = 1'b0; DecodeRd = 5'd0;

    // ---- reset mid-flight: x9, x14, x15 pending, two results queued
    LuIssue = 1'b1; LuIssueRegister = 5'd14; step();
    LuIssueRegister = 5'd15; step();
    LuIssue = 1'b0;
    WbWriteEnable = 1'b1; WbRegister = 5'd1; WbData = 32'h201;
    LuResultValid = 1'b1; LuResultRegister = 5'd14; LuResultData = 32'hE;
    #1; chk_port("mid.wb1", 1'b1, 5'd1, 32'h201);
    step();
    WbRegister = 5'd2; WbData = 32'h202;
    LuResultRegister = 5'd15; LuResultData = 32'hF;
    step();
    rst = 1'b1; WbRegister = 5'd3; WbData = 32'h203; LuResultValid = 1'b0;
    DecodeRs1 = 5'd9;
    #1; chk_port("mid.rst_cycle", 1'b0, 5'd0, 32'd0);
    chk("mid.rst_err", {31'd0, ErrorWaw}, 32'd0);
    chk("mid.rst_stall", {31'd0, StallD}, 32'd0);
    chk("mid.rst_res_rdy", {31'd0, LuResultReady}, 32'd0);
    step();
    rst = 1'b0; WbWriteEnable = 1'b0; LuIssueRegister = 5'd9;
    #1; chk_port("mid.dropped", 1'b0, 5'd0, 32'd0);
    chk("mid.err_clr", {31'd0, ErrorWaw}, 32'd0);
    chk("mid.stall_x9", {31'd0, StallD}, 32'd0);
    chk("mid.res_rdy", {31'd0, LuResultReady}, 32'd1);
    chk("mid.issue_x9", {31'd0, LuIssueReady}, 32'd1);
    DecodeRs1 = 5'd14; DecodeRs2 = 5'd15;
    #1; chk("mid.stall_x14_15", {31'd0, StallD}, 32'd0);
    step();
    #1; chk_port("mid.still_empty", 1'b0, 5'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
